// File: rtl/i2s_tx_serializer_if.sv
// I2S transmit bundle: upstream sample handshake and DAC-side pins.
// Member names are written from the serializer's point of view.
interface i2s_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 24
);
  logic                 i_Enable;
  logic [DATA_BITS-1:0] i_LeftData;
  logic [DATA_BITS-1:0] i_RightData;
  logic                 o_ReqNextData;
  logic                 o_Busy;
  logic                 o_SDIN;
  logic                 o_SCLK;
  logic                 o_LRCK;
  logic                 o_MCLK;

  modport master (
    output i_Enable, i_LeftData, i_RightData,
    input  o_ReqNextData, o_Busy, o_SDIN, o_SCLK, o_LRCK, o_MCLK
  );

  modport slave (
    input  i_Enable, i_LeftData, i_RightData,
    output o_ReqNextData, o_Busy, o_SDIN, o_SCLK, o_LRCK, o_MCLK
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one stereo pair per frame, enable with prime and drain-to-frame-end.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (no 1-bit delay, LRCK high = left).
module i2s_tx_serializer #(
  parameter int unsigned DATA_BITS    = 24,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned SCLK_HALF    = 4,
  parameter int unsigned REQ_BIT      = 48,
  parameter int unsigned PRIME_CYCLES = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  i2s_tx_serializer_if.slave io
);
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned PH_W       = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned PR_W       = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int unsigned L_SHIFT_HI = DATA_BITS - 1;
  localparam int unsigned R_FIRST    = SLOT_BITS;
`else
  localparam int unsigned L_SHIFT_HI = DATA_BITS;
  localparam int unsigned R_FIRST    = SLOT_BITS + 1;
`endif
  localparam int unsigned R_LAST     = R_FIRST + DATA_BITS - 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_STOP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [PH_W-1:0]      r_phase;
  logic [PR_W-1:0]      r_prime_cnt;
  logic [BIT_W-1:0]     r_bitcnt;
  logic [DATA_BITS-1:0] r_left_sr;
  logic [DATA_BITS-1:0] r_right_sr;
  logic                 r_req;
  logic                 r_busy;
  logic                 r_sdin;
  logic                 r_sclk;
  logic                 r_lrck;
  logic                 r_mclk;

  logic                 w_ph_term;
  logic                 w_sclk_fall;
  logic                 w_wrap;
  logic                 w_prime_done;
  logic [BIT_W-1:0]     w_bit_next;
  logic                 w_in_left;
  logic                 w_in_right;
  logic                 w_cap_sdin;
  logic [DATA_BITS-1:0] w_cap_left;

  function automatic logic f_lrck(input logic [BIT_W-1:0] b);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return b < BIT_W'(SLOT_BITS);
`else
    return b >= BIT_W'(SLOT_BITS);
`endif
  endfunction

  assign w_ph_term    = (r_phase == PH_W'(SCLK_HALF - 1));
  assign w_sclk_fall  = w_ph_term && r_sclk;
  assign w_wrap       = w_sclk_fall && (r_bitcnt == BIT_W'(FRAME_BITS - 1));
  assign w_prime_done = (r_prime_cnt == PR_W'(PRIME_CYCLES - 1));
  assign w_bit_next   = (r_bitcnt == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bitcnt + BIT_W'(1);
  assign w_in_left    = (w_bit_next >= BIT_W'(1)) && (w_bit_next <= BIT_W'(L_SHIFT_HI));
  assign w_in_right   = (w_bit_next >= BIT_W'(R_FIRST)) && (w_bit_next <= BIT_W'(R_LAST));

  // Left-justified puts the left MSB on the wire at the frame-start edge itself.
`ifdef I2S_LEFT_JUSTIFIED_EN
  assign w_cap_sdin = io.i_LeftData[DATA_BITS-1];
  assign w_cap_left = {io.i_LeftData[DATA_BITS-2:0], 1'b0};
`else
  assign w_cap_sdin = 1'b0;
  assign w_cap_left = io.i_LeftData;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Disable at the frame boundary goes straight to IDLE; otherwise drain in STOP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io.i_Enable) w_next = S_PRIME;
      S_PRIME: if (w_prime_done) w_next = S_RUN;
      S_RUN:   if (!io.i_Enable) w_next = w_wrap ? S_IDLE : S_STOP;
      S_STOP: begin
        if (io.i_Enable)  w_next = S_RUN;
        else if (w_wrap)  w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || w_next == S_IDLE) begin
      r_phase     <= '0;
      r_prime_cnt <= '0;
      r_bitcnt    <= '0;
      r_left_sr   <= '0;
      r_right_sr  <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_sdin      <= 1'b0;
      r_sclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_mclk      <= 1'b0;
    end else begin
      r_busy <= 1'b1;
      r_mclk <= r_busy & ~r_mclk;
      if (r_state == S_IDLE) begin
        r_req       <= 1'b1;
        r_prime_cnt <= '0;
      end else if (r_state == S_PRIME) begin
        if (w_next == S_RUN) begin
          r_left_sr  <= w_cap_left;
          r_right_sr <= io.i_RightData;
          r_sdin     <= w_cap_sdin;
          r_lrck     <= f_lrck('0);
          r_req      <= 1'b0;
          r_bitcnt   <= '0;
          r_phase    <= '0;
          r_sclk     <= 1'b0;
        end else begin
          r_prime_cnt <= r_prime_cnt + PR_W'(1);
        end
      end else begin
        // Re-enabled from STOP after the request point: request right away.
        if (r_state == S_STOP && w_next == S_RUN && r_bitcnt >= BIT_W'(REQ_BIT))
          r_req <= 1'b1;
        if (w_ph_term) begin
          r_phase <= '0;
          r_sclk  <= ~r_sclk;
        end else begin
          r_phase <= r_phase + PH_W'(1);
        end
        if (w_sclk_fall) begin
          r_bitcnt <= w_bit_next;
          r_lrck   <= f_lrck(w_bit_next);
          if (w_wrap) begin
            r_left_sr  <= w_cap_left;
            r_right_sr <= io.i_RightData;
            r_sdin     <= w_cap_sdin;
            r_req      <= 1'b0;
          end else begin
            if (w_bit_next == BIT_W'(REQ_BIT) && w_next == S_RUN)
              r_req <= 1'b1;
            if (w_in_left) begin
              r_sdin    <= r_left_sr[DATA_BITS-1];
              r_left_sr <= r_left_sr << 1;
            end else if (w_in_right) begin
              r_sdin     <= r_right_sr[DATA_BITS-1];
              r_right_sr <= r_right_sr << 1;
            end else begin
              r_sdin <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign io.o_ReqNextData = r_req;
  assign io.o_Busy        = r_busy;
  assign io.o_SDIN        = r_sdin;
  assign io.o_SCLK        = r_sclk;
  assign io.o_LRCK        = r_lrck;
  assign io.o_MCLK        = r_mclk;
endmodule
